mfp_avalon_arbiter: RTL and testbench

- Two-master to one-slave Avalon-MM arbiter. It shares the single LPDDR2 memory-controller port between the CPU memory bridge (m0) and a second bus master (m1, e.g. DMA or video fetch).
- Sits between the masters and the lpddr2_mm controller, all in the avm_clk domain.
- Arbitration is round-robin with burst locking for writes.
- Pipelined read bursts are routed back to the issuing master through an in-order tag FIFO.

---
 rtl/mfp_avalon_arbiter_pkg.sv | 20 ++
 rtl/mfp_avalon_arb_tag_fifo.sv | 50 +++++
 rtl/mfp_avalon_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mfp_avalon_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_avalon_arbiter_pkg.sv
// Shared definitions for the two-master Avalon-MM arbiter: FSM states,
// master ids and default bus widths.
package mfp_avalon_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W   = 27;
  localparam int unsigned ARB_DATA_W   = 32;
  localparam int unsigned ARB_BE_W     = 4;
  localparam int unsigned ARB_BURST_W  = 3;
  localparam int unsigned ARB_MAX_PEND = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_CMD    = 2'd1,
    ARB_WBURST = 2'd2
  } arb_state_t;

  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;

endpackage

// File: rtl/mfp_avalon_arb_tag_fifo.sv
// In-order tag FIFO of outstanding read commands; each entry is {id, burstcount}.
// Pointers carry one extra wrap bit to distinguish full from empty.
module mfp_avalon_arb_tag_fifo
  import mfp_avalon_arbiter_pkg::*;
#(
  parameter int unsigned BURST_W = ARB_BURST_W,
  parameter int unsigned DEPTH   = ARB_MAX_PEND
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_push_id,
  input  logic [BURST_W-1:0] i_push_bc,
  input  logic               i_pop,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_head_id,
  output logic [BURST_W-1:0] o_head_bc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [BURST_W:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign {o_head_id, o_head_bc} = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= {i_push_id, i_push_bc};
        r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/mfp_avalon_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter: round-robin grants, locked write
// bursts, and read data routed back to the issuer through an in-order tag FIFO.
module mfp_avalon_arbiter
  import mfp_avalon_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ARB_ADDR_W,
  parameter int unsigned DATA_W   = ARB_DATA_W,
  parameter int unsigned BE_W     = ARB_BE_W,
  parameter int unsigned BURST_W  = ARB_BURST_W,
  parameter int unsigned MAX_PEND = ARB_MAX_PEND
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [BE_W-1:0]    m0_byteenable,
  input  logic [BURST_W-1:0] m0_burstcount,
  input  logic [DATA_W-1:0]  m0_writedata,
  output logic               m0_waitrequest,
  output logic               m0_readdatavalid,
  output logic [DATA_W-1:0]  m0_readdata,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [BE_W-1:0]    m1_byteenable,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic [DATA_W-1:0]  m1_writedata,
  output logic               m1_waitrequest,
  output logic               m1_readdatavalid,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               s_read,
  output logic               s_write,
  output logic [ADDR_W-1:0]  s_address,
  output logic [BE_W-1:0]    s_byteenable,
  output logic [BURST_W-1:0] s_burstcount,
  output logic [DATA_W-1:0]  s_writedata,
  input  logic               s_waitrequest,
  input  logic               s_readdatavalid,
  input  logic [DATA_W-1:0]  s_readdata,
  output logic               protocol_err
);

  arb_state_t         r_state;
  logic               r_gnt;
  logic               r_rr_ptr;
  logic [BURST_W-1:0] r_remaining;
  logic [BURST_W-1:0] r_beat;
  logic               r_protocol_err;

  logic               w_sel_read;
  logic               w_sel_write;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [BE_W-1:0]    w_sel_be;
  logic [BURST_W-1:0] w_sel_bc;
  logic [BURST_W-1:0] w_sel_bc_eff;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_m0_elig;
  logic               w_m1_elig;
  logic               w_cmd_out;
  logic               w_sel_wait;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_rvalid;
  logic [BURST_W-1:0] w_beat_next;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_head_id;
  logic [BURST_W-1:0] w_head_bc;

  always_comb begin
    w_sel_read  = m0_read;
    w_sel_write = m0_write;
    w_sel_addr  = m0_address;
    w_sel_be    = m0_byteenable;
    w_sel_bc    = m0_burstcount;
    w_sel_wdata = m0_writedata;
    if (r_gnt == M1_ID) begin
      w_sel_read  = m1_read;
      w_sel_write = m1_write;
      w_sel_addr  = m1_address;
      w_sel_be    = m1_byteenable;
      w_sel_bc    = m1_burstcount;
      w_sel_wdata = m1_writedata;
    end
  end

  assign w_sel_bc_eff = (w_sel_bc == '0) ? BURST_W'(1) : w_sel_bc;

  // A read counts as a request only while the FIFO has room; read wins over write.
  assign w_m0_elig = m0_read ? !w_fifo_full : m0_write;
  assign w_m1_elig = m1_read ? !w_fifo_full : m1_write;

  always_comb begin
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_address    = '0;
    s_byteenable = '0;
    s_burstcount = '0;
    s_writedata  = '0;
    if (r_state == ARB_CMD) begin
      s_read  = w_sel_read && !w_fifo_full;
      s_write = w_sel_write && !w_sel_read;
    end else if (r_state == ARB_WBURST) begin
      s_write = w_sel_write;
    end
    if (r_state != ARB_IDLE) begin
      s_address    = w_sel_addr;
      s_byteenable = w_sel_be;
      s_burstcount = w_sel_bc;
      s_writedata  = w_sel_wdata;
    end
  end

  assign w_cmd_out      = s_read || s_write;
  assign w_sel_wait     = s_waitrequest || !w_cmd_out;
  assign w_accept       = w_cmd_out && !s_waitrequest;
  assign w_push         = (r_state == ARB_CMD) && s_read && !s_waitrequest;
  assign m0_waitrequest = (r_state != ARB_IDLE && r_gnt == M0_ID) ? w_sel_wait : 1'b1;
  assign m1_waitrequest = (r_state != ARB_IDLE && r_gnt == M1_ID) ? w_sel_wait : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_gnt       <= M0_ID;
      r_rr_ptr    <= M0_ID;
      r_remaining <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_m0_elig && w_m1_elig) begin
            r_gnt   <= r_rr_ptr;
            r_state <= ARB_CMD;
          end else if (w_m0_elig) begin
            r_gnt   <= M0_ID;
            r_state <= ARB_CMD;
          end else if (w_m1_elig) begin
            r_gnt   <= M1_ID;
            r_state <= ARB_CMD;
          end
        end
        ARB_CMD: begin
          if (w_accept) begin
            if (s_read) begin
              r_rr_ptr <= !r_gnt;
              r_state  <= ARB_IDLE;
            end else if (w_sel_bc_eff > BURST_W'(1)) begin
              r_remaining <= w_sel_bc_eff - BURST_W'(1);
              r_state     <= ARB_WBURST;
            end else begin
              r_rr_ptr <= !r_rr_ptr;
              r_state  <= ARB_IDLE;
            end
          end else if (!w_cmd_out) begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_WBURST: begin
          if (w_accept) begin
            r_remaining <= r_remaining - BURST_W'(1);
            if (r_remaining == BURST_W'(1)) begin
              r_rr_ptr <= !r_rr_ptr;
              r_state  <= ARB_IDLE;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  mfp_avalon_arb_tag_fifo #(
    .BURST_W (BURST_W),
    .DEPTH   (MAX_PEND)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_push_id (r_gnt),
    .i_push_bc (w_sel_bc_eff),
    .i_pop     (w_pop),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_head_id (w_head_id),
    .o_head_bc (w_head_bc)
  );

  assign w_rvalid         = s_readdatavalid && !w_fifo_empty;
  assign w_beat_next      = r_beat + BURST_W'(1);
  assign w_pop            = w_rvalid && (w_beat_next == w_head_bc);
  assign m0_readdatavalid = w_rvalid && (w_head_id == M0_ID);
  assign m1_readdatavalid = w_rvalid && (w_head_id == M1_ID);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign protocol_err     = r_protocol_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat         <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_pop) r_beat <= '0;
      else if (w_rvalid) r_beat <= w_beat_next;
      if (s_readdatavalid && w_fifo_empty) r_protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mfp_avalon_arbiter.sv
// Directed bench for mfp_avalon_arbiter: expected commands and read-return
// routing are queued as stimulus is driven and checked when the DUT acts.
module tb_mfp_avalon_arbiter;

  localparam int unsigned ADDR_W   = 27;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned BURST_W  = 3;
  localparam int unsigned MAX_PEND = 4;

  logic clk = 1'b0;
  logic rst;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [ADDR_W-1:0]  m0_address, m1_address;
  logic [BE_W-1:0]    m0_byteenable, m1_byteenable;
  logic [BURST_W-1:0] m0_burstcount, m1_burstcount;
  logic [DATA_W-1:0]  m0_writedata, m1_writedata;
  logic m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [DATA_W-1:0]  m0_readdata, m1_readdata;
  logic s_read, s_write;
  logic [ADDR_W-1:0]  s_address;
  logic [BE_W-1:0]    s_byteenable;
  logic [BURST_W-1:0] s_burstcount;
  logic [DATA_W-1:0]  s_writedata;
  logic s_waitrequest, s_readdatavalid;
  logic [DATA_W-1:0]  s_readdata;
  logic protocol_err;

  mfp_avalon_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W), .MAX_PEND(MAX_PEND)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_burstcount(m1_burstcount),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_byteenable(s_byteenable), .s_burstcount(s_burstcount),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned acc_cnt = 0;
  int unsigned rdv0_cnt = 0;
  int unsigned rdv1_cnt = 0;
  logic [1:0] exp_cmd_q[$];   // {is_read, master id}
  logic       exp_rd_q[$];    // master id per expected read beat
  logic [1:0] mon_e;
  logic       mon_id;
  logic [DATA_W-1:0] rd_data_drv = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ((s_read || s_write) && !s_waitrequest) begin
        acc_cnt++;
        if (exp_cmd_q.size() == 0) begin
          chk("unexpected_cmd", 32'({s_read, s_write}), 32'(0));
        end else begin
          mon_e = exp_cmd_q.pop_front();
          chk("cmd_waitreq", 32'({m0_waitrequest, m1_waitrequest}), mon_e[0] ? 32'(2) : 32'(1));
          chk("cmd_is_read", 32'(s_read), 32'(mon_e[1]));
          chk("cmd_addr", 32'(s_address), mon_e[0] ? 32'(m1_address) : 32'(m0_address));
          chk("cmd_be", 32'(s_byteenable), mon_e[0] ? 32'(m1_byteenable) : 32'(m0_byteenable));
          chk("cmd_bc", 32'(s_burstcount), mon_e[0] ? 32'(m1_burstcount) : 32'(m0_burstcount));
          if (s_write)
            chk("cmd_wdata", s_writedata, mon_e[0] ? m1_writedata : m0_writedata);
        end
      end
      if (m0_readdatavalid || m1_readdatavalid) begin
        if (m0_readdatavalid) rdv0_cnt++;
        if (m1_readdatavalid) rdv1_cnt++;
        if (exp_rd_q.size() == 0) begin
          chk("unexpected_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'(0));
        end else begin
          mon_id = exp_rd_q.pop_front();
          chk("rdv_route", 32'({m0_readdatavalid, m1_readdatavalid}), mon_id ? 32'(1) : 32'(2));
          chk("rdv_data", mon_id ? m1_readdata : m0_readdata, rd_data_drv);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic wait_of(input logic m);
    return m ? m1_waitrequest : m0_waitrequest;
  endfunction

  task automatic drive(input logic m, input logic rd, input logic wr,
                       input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc,
                       input logic [DATA_W-1:0] wd);
    if (m) begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_burstcount = bc; m1_writedata = wd;
    end else begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_burstcount = bc; m0_writedata = wd;
    end
  endtask

  task automatic idle_masters();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Single command from one master; returns at posedge+1 after acceptance.
  task automatic issue(input logic m, input logic rd, input logic [ADDR_W-1:0] a,
                       input logic [BURST_W-1:0] bc);
    int unsigned budget = 20;
    int unsigned nb = (bc == '0) ? 1 : int'(bc);
    exp_cmd_q.push_back({rd, m});
    if (rd) for (int unsigned i = 0; i < nb; i++) exp_rd_q.push_back(m);
    drive(m, rd, !rd, a, bc, $urandom);
    @(negedge clk);
    while (wait_of(m) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("issue_timeout", 32'(wait_of(m)), 32'(0));
    tick();
    drive(m, 1'b0, 1'b0, a, bc, '0);
  endtask

  task automatic beat(input logic v);
    rd_data_drv     = $urandom;
    s_readdata      = rd_data_drv;
    s_readdatavalid = v;
    tick();
    s_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_masters();
    s_waitrequest = 1'b0;
    s_readdatavalid = 1'b0;
    exp_cmd_q.delete();
    exp_rd_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b0, b1, target, budget;
    rst = 1'b1;
    idle_masters();
    m0_byteenable = 4'h3;
    m1_byteenable = 4'hC;
    s_waitrequest = 1'b0;
    s_readdatavalid = 1'b0;
    s_readdata = '0;
    #1;
    chk("rst_s_cmd", 32'({s_read, s_write}), 32'(0));
    chk("rst_s_addr", 32'(s_address), 32'(0));
    chk("rst_waitreq", 32'({m0_waitrequest, m1_waitrequest}), 32'(3));
    chk("rst_perr", 32'(protocol_err), 32'(0));
    do_reset();

    // 1: single m0 read burst of 4 with gapped returns
    b0 = rdv0_cnt; b1 = rdv1_cnt;
    exp_cmd_q.push_back({1'b1, 1'b0});
    for (int unsigned i = 0; i < 4; i++) exp_rd_q.push_back(1'b0);
    drive(1'b0, 1'b1, 1'b0, 27'h100, 3'd4, '0);
    @(negedge clk);
    chk("t1_sread_idle", 32'(s_read), 32'(0));
    chk("t1_m0_wait_idle", 32'(m0_waitrequest), 32'(1));
    tick();
    @(negedge clk);
    chk("t1_sread_cmd", 32'(s_read), 32'(1));
    chk("t1_m1_wait", 32'(m1_waitrequest), 32'(1));
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    chk("t1_sread_done", 32'(s_read), 32'(0));
    tick();
    beat(1); beat(0); beat(1); beat(1); beat(0); beat(0); beat(1); beat(0);
    chk("t1_m0_beats", rdv0_cnt - b0, 4);
    chk("t1_m1_beats", rdv1_cnt - b1, 0);
    chk("t1_fifo_empty", 32'(dut.w_fifo_empty), 32'(1));

    // 2: both masters write continuously, grants alternate from m0
    do_reset();
    exp_cmd_q.push_back(2'b00); exp_cmd_q.push_back(2'b01);
    exp_cmd_q.push_back(2'b00); exp_cmd_q.push_back(2'b01);
    drive(1'b0, 1'b0, 1'b1, 27'h200, 3'd1, 32'hA0A0_0000);
    drive(1'b1, 1'b0, 1'b1, 27'h300, 3'd1, 32'hB1B1_1111);
    @(negedge clk);
    chk("t2_both_wait_idle", 32'({m0_waitrequest, m1_waitrequest}), 32'(3));
    target = acc_cnt + 4;
    budget = 30;
    while (acc_cnt < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("t2_accepts", acc_cnt, target);
    #1;
    idle_masters();
    chk("t2_queue_drained", exp_cmd_q.size(), 0);

    // 3: m1 write burst of 3 with a stalled beat locks out m0's read
    tick();
    exp_cmd_q.push_back(2'b01); exp_cmd_q.push_back(2'b01); exp_cmd_q.push_back(2'b01);
    exp_cmd_q.push_back(2'b10);
    exp_rd_q.push_back(1'b0);
    drive(1'b1, 1'b0, 1'b1, 27'h400, 3'd3, 32'h1111_0001);
    @(negedge clk);
    chk("t3_m1_wait_idle", 32'(m1_waitrequest), 32'(1));
    tick();
    drive(1'b0, 1'b1, 1'b0, 27'h500, 3'd1, '0);
    @(negedge clk);
    chk("t3_m1_beat1", 32'(m1_waitrequest), 32'(0));
    chk("t3_m0_blk1", 32'(m0_waitrequest), 32'(1));
    tick();
    m1_writedata = 32'h1111_0002;
    s_waitrequest = 1'b1;
    @(negedge clk);
    chk("t3_m1_stall", 32'(m1_waitrequest), 32'(1));
    chk("t3_swrite_held", 32'(s_write), 32'(1));
    chk("t3_m0_blk2", 32'(m0_waitrequest), 32'(1));
    tick();
    s_waitrequest = 1'b0;
    tick();
    m1_writedata = 32'h1111_0003;
    @(negedge clk);
    chk("t3_m0_blk3", 32'(m0_waitrequest), 32'(1));
    tick();
    m1_write = 1'b0;
    @(negedge clk);
    chk("t3_gap_sread", 32'(s_read), 32'(0));
    chk("t3_gap_m0_wait", 32'(m0_waitrequest), 32'(1));
    tick();
    @(negedge clk);
    chk("t3_m0_granted", 32'(m0_waitrequest), 32'(0));
    chk("t3_m0_sread", 32'(s_read), 32'(1));
    tick();
    m0_read = 1'b0;
    beat(1);
    chk("t3_queues", exp_cmd_q.size() + exp_rd_q.size(), 0);

    // 4: interleaved reads return in issue order
    b0 = rdv0_cnt; b1 = rdv1_cnt;
    issue(1'b0, 1'b1, 27'h600, 3'd2);
    issue(1'b1, 1'b1, 27'h610, 3'd1);
    issue(1'b0, 1'b1, 27'h620, 3'd3);
    chk("t4_no_early_rdv", (rdv0_cnt - b0) + (rdv1_cnt - b1), 0);
    for (int unsigned i = 0; i < 6; i++) beat(1);
    chk("t4_m0_beats", rdv0_cnt - b0, 5);
    chk("t4_m1_beats", rdv1_cnt - b1, 1);
    chk("t4_rd_queue", exp_rd_q.size(), 0);

    // 5: full FIFO holds a fifth read until the first pop; burstcount 0 is one beat
    issue(1'b0, 1'b1, 27'h700, 3'd0);
    issue(1'b1, 1'b1, 27'h710, 3'd1);
    issue(1'b0, 1'b1, 27'h720, 3'd1);
    issue(1'b1, 1'b1, 27'h730, 3'd1);
    exp_cmd_q.push_back(2'b10);
    exp_rd_q.push_back(1'b0);
    drive(1'b0, 1'b1, 1'b0, 27'h740, 3'd1, '0);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_held_wait", 32'(m0_waitrequest), 32'(1));
      chk("t5_held_sread", 32'(s_read), 32'(0));
    end
    tick();
    beat(1);
    budget = 10;
    @(negedge clk);
    while (m0_waitrequest && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("t5_fifth_granted", 32'(m0_waitrequest), 32'(0));
    tick();
    m0_read = 1'b0;
    for (int unsigned i = 0; i < 4; i++) beat(1);
    chk("t5_rd_queue", exp_rd_q.size(), 0);
    chk("t5_perr_clean", 32'(protocol_err), 32'(0));
    beat(1);
    chk("t5_perr_set", 32'(protocol_err), 32'(1));
    tick(); tick(); tick();
    chk("t5_perr_sticky", 32'(protocol_err), 32'(1));

    // 6: reset in the middle of a write burst with two reads pending
    do_reset();
    chk("t6_perr_cleared", 32'(protocol_err), 32'(0));
    issue(1'b0, 1'b1, 27'h800, 3'd1);
    issue(1'b1, 1'b1, 27'h810, 3'd2);
    exp_cmd_q.push_back(2'b00); exp_cmd_q.push_back(2'b00);
    drive(1'b0, 1'b0, 1'b1, 27'h820, 3'd4, 32'hC0DE_0001);
    budget = 10;
    @(negedge clk);
    while (m0_waitrequest && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tick();
    m0_writedata = 32'hC0DE_0002;
    @(negedge clk);
    chk("t6_wburst_m0", 32'(m0_waitrequest), 32'(0));
    tick();
    #2;
    rst = 1'b1;
    m0_write = 1'b0;
    #1;
    chk("t6_rst_s_cmd", 32'({s_read, s_write}), 32'(0));
    chk("t6_rst_s_addr", 32'(s_address), 32'(0));
    chk("t6_rst_waitreq", 32'({m0_waitrequest, m1_waitrequest}), 32'(3));
    chk("t6_rst_fifo_empty", 32'(dut.w_fifo_empty), 32'(1));
    exp_rd_q.delete();
    chk("t6_cmd_queue", exp_cmd_q.size(), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    b0 = rdv0_cnt; b1 = rdv1_cnt;
    beat(1); beat(1); beat(1);
    chk("t6_no_stale_rdv", (rdv0_cnt - b0) + (rdv1_cnt - b1), 0);
    chk("t6_perr_stale", 32'(protocol_err), 32'(1));
    target = acc_cnt + 1;
    issue(1'b1, 1'b0, 27'h900, 3'd1);
    chk("t6_regrant", acc_cnt, target);
    chk("t6_queues", exp_cmd_q.size() + exp_rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
